// File: rtl/mc_core_hs.sv
// mc_core_hs: multicycle MIPS-subset core (datapath and control FSM in one block).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   mem_req    memory request valid (FETCH, MEM_RD, MEM_WR only)
//   mem_we     1 = write, 0 = read; meaningful while mem_req
//   mem_addr   word address (PC during fetch, ALUOut during data access)
//   mem_wdata  store data (B register)
//   mem_rdata  read data; instruction is taken from the low 32 bits
//   mem_ready  completes the transfer in a cycle where mem_req is high
//   pc         current program counter (word address)
//   retire     one-cycle pulse in the last cycle of each instruction
//   halted     core stopped on an illegal opcode / funct
//   dbg_addr   debug register index
//   dbg_data   combinational read of register dbg_addr (r0 reads 0)
//   dbg_state  current FSM state encoding
//
// Handshake: a transfer is offered with mem_req=1; mem_addr, mem_we and
// mem_wdata stay constant until the cycle in which mem_ready=1, which is the
// cycle the transfer completes. mem_ready is ignored whenever mem_req=0, and
// mem_req is forced low while rst=0 so a reset simply drops any open transfer.

module mc_core_hs #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 16,
  parameter int NREG = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  input  logic [4:0]        dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [3:0]        dbg_state
);

  localparam int RIDX_W = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_ir;
  logic [XLEN-1:0]     r_mdr, r_a, r_b, r_aluout;
  logic                r_halted;
  logic [XLEN-1:0]     r_rf [NREG];

  logic [5:0]          w_op, w_funct;
  logic [RIDX_W-1:0]   w_rs_idx, w_rt_idx, w_rd_idx;
  logic [XLEN-1:0]     w_simm, w_pc_x, w_alu_r;
  logic                w_rtype_ok;
  logic [ADDR_W-1:0]   w_jtarget;
  logic                w_rf_we;
  logic [RIDX_W-1:0]   w_rf_widx;
  logic [XLEN-1:0]     w_rf_wdata;
  logic                w_unused;

  // Instruction fields; register indices keep only the low log2(NREG) bits.
  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_rs_idx  = r_ir[21 +: RIDX_W];
  assign w_rt_idx  = r_ir[16 +: RIDX_W];
  assign w_rd_idx  = r_ir[11 +: RIDX_W];
  assign w_simm    = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
  assign w_pc_x    = XLEN'(r_pc);
  assign w_jtarget = ADDR_W'(r_ir[25:0]);
  assign w_unused  = ^r_ir[10:6];

  // R-type ALU and funct legality.
  always_comb begin
    w_alu_r    = '0;
    w_rtype_ok = 1'b1;
    case (w_funct)
      6'h20:   w_alu_r = r_a + r_b;
      6'h22:   w_alu_r = r_a - r_b;
      6'h24:   w_alu_r = r_a & r_b;
      6'h25:   w_alu_r = r_a | r_b;
      6'h2A:   w_alu_r = ($signed(r_a) < $signed(r_b)) ? XLEN'(1) : '0;
      default: w_rtype_ok = 1'b0;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // FSM: next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_RTYPE:      w_next = w_rtype_ok ? S_EXEC_R : S_HALT;
          OP_ADDI:       w_next = S_EXEC_I;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          default:       w_next = S_HALT;
        endcase
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_WB_R:     w_next = S_FETCH;
      S_EXEC_I:   w_next = S_WB_I;
      S_WB_I:     w_next = S_FETCH;
      S_MEM_ADDR: w_next = (w_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // FSM: outputs. Request and retire are gated by rst so reset drops them at once.
  always_comb begin
    mem_req = rst && (r_state == S_FETCH || r_state == S_MEM_RD || r_state == S_MEM_WR);
    mem_we  = (r_state == S_MEM_WR);
    mem_addr = (r_state == S_FETCH) ? r_pc : r_aluout[ADDR_W-1:0];
    mem_wdata = r_b;
    retire = rst && (r_state == S_WB_R || r_state == S_WB_I || r_state == S_MEM_WB ||
                     r_state == S_BRANCH || r_state == S_JUMP ||
                     (r_state == S_MEM_WR && mem_ready));
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir <= mem_rdata[31:0];
          r_pc <= r_pc + ADDR_W'(1);
        end
        S_DECODE: begin
          r_a      <= r_rf[w_rs_idx];
          r_b      <= r_rf[w_rt_idx];
          // PC already points past this instruction, so this is the branch target.
          r_aluout <= w_pc_x + w_simm;
          if (w_next == S_HALT) r_halted <= 1'b1;
        end
        S_EXEC_R:             r_aluout <= w_alu_r;
        S_EXEC_I, S_MEM_ADDR: r_aluout <= r_a + w_simm;
        S_MEM_RD:             if (mem_ready) r_mdr <= mem_rdata;
        S_BRANCH:             if ((r_a == r_b) ^ (w_op == OP_BNE)) r_pc <= r_aluout[ADDR_W-1:0];
        S_JUMP:               r_pc <= w_jtarget;
        default: ;
      endcase
    end
  end

  // Register file write port selection.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_widx  = w_rt_idx;
    w_rf_wdata = r_aluout;
    case (r_state)
      S_WB_R: begin
        w_rf_we   = 1'b1;
        w_rf_widx = w_rd_idx;
      end
      S_WB_I:   w_rf_we = 1'b1;
      S_MEM_WB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_mdr;
      end
      default: ;
    endcase
  end

  // r0 is never written, so it keeps its reset value of zero on every read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_rf_we && (w_rf_widx != '0)) begin
      r_rf[w_rf_widx] <= w_rf_wdata;
    end
  end

  assign pc        = r_pc;
  assign halted    = r_halted;
  assign dbg_data  = r_rf[dbg_addr[RIDX_W-1:0]];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mc_core_hs.sv
// Testbench for mc_core_hs: directed programs plus a randomized instruction
// stream with random wait states, checked against an instruction-level model.
module tb_mc_core_hs;

  localparam int XLEN = 32;
  localparam int ADDR_W = 16;
  localparam int NREG = 32;
  localparam logic [15:0] RESET_PC = 16'h0010;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic [XLEN-1:0]   mem_wdata, mem_rdata, dbg_data;
  logic              retire, halted;
  logic [4:0]        dbg_addr;
  logic [3:0]        dbg_state;

  always #5 clk = ~clk;

  mc_core_hs #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NREG(NREG), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ---------------- memory, model, scoreboard ----------------
  logic [31:0] mem [0:65535];
  bit          gen [0:65535];
  logic [31:0] m_reg [0:31];
  logic [15:0] m_pc;
  logic [63:0] exp_q [$];   // expected stores: {16'h0, addr, data}

  int n_tests = 0;
  int n_fail = 0;

  bit          in_xfer, hold_ready, first_seen;
  int          wait_left, fixed_wait;
  int          waits_this, xfers_this, last_cycles;
  logic [15:0] x_addr, first_addr;
  logic        x_we, first_we;
  logic [31:0] x_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] gen_instr();
    int k;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [31:0] r;
    k  = $urandom_range(0, 9);
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    case (k)
      0, 1, 2, 3, 4: r = {6'h00, rs, rt, rd, 5'h00, fn};
      5: r = {6'h08, rs, rt, 16'($urandom)};
      6: r = {6'h23, 5'd0, rt, 16'h0100 + 16'($urandom_range(0, 31))};
      7: r = {6'h2B, 5'd0, rt, 16'h0100 + 16'($urandom_range(0, 31))};
      8: r = {($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05, rs, rt,
              16'($urandom_range(0, 6)) - 16'd3};
      default: r = {6'h02, 10'($urandom), 16'($urandom_range(16'h0200, 16'hFEFF))};
    endcase
    return r;
  endfunction

  // ---------------- driver: one clock cycle of memory responder ----------------
  // Called at a negedge; returns whether retire was high in this cycle.
  task automatic do_cycle(output bit ret);
    logic [63:0] e;
    if (mem_req && !in_xfer) begin
      in_xfer = 1'b1;
      x_addr = mem_addr; x_we = mem_we; x_wdata = mem_wdata;
      wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 2);
      if (!first_seen) begin
        first_seen = 1'b1; first_addr = mem_addr; first_we = mem_we;
      end
    end else if (mem_req) begin
      check("hold_addr", mem_addr, x_addr);
      check("hold_we", mem_we, x_we);
      check("hold_wdata", mem_wdata, x_wdata);
    end
    mem_ready = mem_req && !hold_ready && (wait_left == 0);
    mem_rdata = mem_ready ? mem[mem_addr] : $urandom;
    if (mem_req && !mem_ready) waits_this++;
    #1;
    ret = retire;
    if (mem_req && mem_ready) begin
      xfers_this++;
      in_xfer = 1'b0;
      if (mem_we) begin
        check("store_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("store_addr_data", {16'h0, mem_addr, mem_wdata}, e);
        end
        mem[mem_addr] = mem_wdata;
        gen[mem_addr] = 1'b1;
      end
    end else if (mem_req) begin
      wait_left--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("req_in_reset", mem_req, 0);
      check("retire_in_reset", retire, 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    in_xfer = 1'b0;
    exp_q.delete();
    m_pc = RESET_PC;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    #1;
    check("reset_pc", pc, RESET_PC);
    check("reset_halted", halted, 0);
    check("reset_req", mem_req, 1);
    check("reset_addr", mem_addr, RESET_PC);
    check("reset_we", mem_we, 0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("reset_reg", dbg_data, 0);
    end
  endtask

  // ---------------- model step + one DUT instruction ----------------
  task automatic run_instr();
    logic [31:0] ins, a, b, simm, res;
    logic [5:0]  op, fn;
    logic [15:0] npc, ea;
    int rs, rt, rd, base, nx, wr_idx, cyc;
    bit ret;
    if (!gen[m_pc]) begin
      mem[m_pc] = gen_instr();
      gen[m_pc] = 1'b1;
    end
    ins = mem[m_pc];
    op = ins[31:26]; fn = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    a = m_reg[rs]; b = m_reg[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 16'd1;
    wr_idx = 0; res = '0; nx = 1; base = 0; ea = '0;
    case (op)
      6'h00: begin
        base = 4; wr_idx = rd;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: base = 0;
        endcase
      end
      6'h08: begin base = 4; wr_idx = rt; res = a + simm; end
      6'h23: begin base = 5; nx = 2; wr_idx = rt; ea = 16'(a + simm); res = mem[ea]; end
      6'h2B: begin base = 4; nx = 2; ea = 16'(a + simm); exp_q.push_back({16'h0, ea, b}); end
      6'h04, 6'h05: begin
        base = 3;
        if ((a == b) != (op == 6'h05)) npc = m_pc + 16'd1 + simm[15:0];
      end
      6'h02: begin base = 3; npc = ins[15:0]; end
      default: base = 0;
    endcase
    if (base == 0) return;
    waits_this = 0; xfers_this = 0; first_seen = 1'b0;
    cyc = 0; ret = 1'b0;
    while (!ret && cyc < 60) begin
      do_cycle(ret);
      cyc++;
    end
    last_cycles = cyc;
    check("retire_seen", ret, 1);
    check("cycles", cyc, base + waits_this);
    check("xfers", xfers_this, nx);
    check("fetch_addr", first_addr, m_pc);
    check("fetch_we", first_we, 0);
    check("stores_left", exp_q.size(), 0);
    exp_q.delete();
    if (wr_idx != 0) m_reg[wr_idx] = res;
    m_pc = npc;
    check("pc", pc, m_pc);
    check("retire_pulse", retire, 0);
    if (wr_idx != 0) begin
      dbg_addr = 5'(wr_idx);
      #1;
      check("reg_write", dbg_data, m_reg[wr_idx]);
    end
  endtask

  task automatic read_reg_check(input string tag, input int idx, input logic [31:0] exp);
    dbg_addr = 5'(idx);
    #1;
    check(tag, dbg_data, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ret;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; gen[i] = 1'b0; end
    mem[16'h10] = i_type(6'h08, 0, 1, 16'd5);
    mem[16'h11] = i_type(6'h08, 0, 2, 16'hFFFD);
    mem[16'h12] = r_type(1, 2, 3, 6'h20);
    mem[16'h13] = r_type(2, 1, 4, 6'h2A);
    mem[16'h14] = i_type(6'h2B, 0, 1, 16'd4);
    mem[16'h15] = i_type(6'h23, 0, 5, 16'd4);
    mem[16'h16] = i_type(6'h04, 1, 1, 16'hFFFF);
    mem[16'h17] = {6'h02, 26'h3FF00};
    mem[16'hFF00] = i_type(6'h08, 1, 0, 16'd7);
    for (int i = 16'h10; i <= 16'h17; i++) gen[i] = 1'b1;
    gen[16'hFF00] = 1'b1;
    for (int i = 16'h100; i < 16'h120; i++) begin mem[i] = $urandom; gen[i] = 1'b1; end
    mem_ready = 1'b0; mem_rdata = '0; dbg_addr = '0;
    fixed_wait = 0; hold_ready = 1'b0; in_xfer = 1'b0;

    @(negedge clk);
    pulse_reset(3);

    // zero-wait arithmetic
    for (int i = 0; i < 4; i++) begin
      run_instr();
      check("zw_retire_cycle", last_cycles, 4);
    end
    read_reg_check("r3_add", 3, 32'd2);
    read_reg_check("r4_slt", 4, 32'd1);

    // store / load with two wait cycles per transfer
    fixed_wait = 2;
    run_instr();
    check("sw_cycles", last_cycles, 8);
    check("sw_mem", mem[4], 32'd5);
    run_instr();
    check("lw_cycles", last_cycles, 9);
    read_reg_check("r5_lw", 5, 32'd5);

    // branches (taken loop twice, then not-taken), jump, r0 write
    fixed_wait = -1;
    run_instr();
    check("beq_loop_pc", pc, 16'h0016);
    run_instr();
    check("beq_loop_pc2", pc, 16'h0016);
    mem[16'h16] = i_type(6'h05, 1, 1, 16'hFFFF);
    run_instr();
    check("bne_nt_pc", pc, 16'h0017);
    run_instr();
    check("jump_pc", pc, 16'hFF00);
    run_instr();
    read_reg_check("r0_zero", 0, 32'd0);

    // random instruction stream with random wait states
    for (int i = 0; i < 150; i++) run_instr();
    for (int i = 0; i < 32; i++) read_reg_check("final_reg", i, m_reg[i]);

    // illegal opcode halts
    fixed_wait = 0;
    mem[m_pc] = 32'hFC00_0000;
    gen[m_pc] = 1'b1;
    do_cycle(ret);
    check("halt_fetch_retire", ret, 0);
    do_cycle(ret);
    check("halt_decode_retire", ret, 0);
    check("halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      check("halt_req", mem_req, 0);
      check("halt_pc", pc, m_pc + 16'd1);
      check("halt_retire", retire, 0);
      do_cycle(ret);
    end

    // reset out of halt, then reset in the middle of a stalled fetch
    pulse_reset(1);
    hold_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle(ret);
    check("stall_req", mem_req, 1);
    pulse_reset(1);
    hold_ready = 1'b0;
    run_instr();
    check("restart_cycles", last_cycles, 4);
    read_reg_check("restart_r1", 1, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
